// File: rtl/clk_div_chain_pkg.sv
// Shared constants for the cascaded tick divider chain.
// Default ratios turn a 100 MHz clk into 1 MHz / 1 kHz / 100 Hz / 1 Hz ticks.
package clk_div_chain_pkg;

  localparam int CNT_W_DEF = 10;

  localparam int DIV_1MHZ  = 100;
  localparam int DIV_1KHZ  = 1000;
  localparam int DIV_100HZ = 10;
  localparam int DIV_1HZ   = 100;

  // Stage 0 in the LSBs; spare top field repeats the 1 Hz ratio.
  localparam logic [5*CNT_W_DEF-1:0] DIV_INIT_DEF = {
    CNT_W_DEF'(DIV_1HZ),
    CNT_W_DEF'(DIV_1HZ),
    CNT_W_DEF'(DIV_100HZ),
    CNT_W_DEF'(DIV_1KHZ),
    CNT_W_DEF'(DIV_1MHZ)
  };

endpackage

// File: rtl/clk_div_stage.sv
// One divider stage: ratio register, counter, lim compare,
// registered tick and square-wave toggle.
module clk_div_stage
  import clk_div_chain_pkg::*;
#(
  parameter int               CNT_W   = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DIV_RST = CNT_W'(1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             strobe_in,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] div_in,
  output logic             strobe_out,
  output logic             tick,
  output logic             sq
);

  logic [CNT_W-1:0] div;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] lim;
  logic             at_lim;

  // A zero ratio behaves as one: the stage passes every strobe.
  assign lim        = (div == '0) ? '0 : div - CNT_W'(1);
  assign at_lim     = (cnt == lim);
  assign strobe_out = strobe_in & at_lim;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div  <= DIV_RST;
      cnt  <= '0;
      tick <= 1'b0;
      sq   <= 1'b0;
    end else if (load) begin
      div  <= div_in;
      cnt  <= '0;
      tick <= 1'b0;
      sq   <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      tick <= 1'b0;
      sq   <= 1'b0;
    end else begin
      if (strobe_in) begin
        cnt <= at_lim ? '0 : cnt + CNT_W'(1);
      end
      tick <= strobe_out;
      if (strobe_out) begin
        sq <= ~sq;
      end
    end
  end

endmodule

// File: rtl/clk_div_chain.sv
// Parametrised cascade of tick dividers; each stage divides the
// previous stage's strobe. Ticks are clock enables, sq is for LEDs.
module clk_div_chain
  import clk_div_chain_pkg::*;
#(
  parameter int NUM_STAGES = 4,
  parameter int CNT_W      = CNT_W_DEF,
  parameter logic [NUM_STAGES*CNT_W-1:0] DIV_INIT =
    (NUM_STAGES*CNT_W)'(DIV_INIT_DEF)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        run,
  input  logic                        clr,
  input  logic                        cfg_load,
  input  logic [NUM_STAGES*CNT_W-1:0] cfg_div,
  output logic [NUM_STAGES-1:0]       tick_o,
  output logic [NUM_STAGES-1:0]       sq_o
);

  logic [NUM_STAGES:0] s;

  assign s[0] = run;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    clk_div_stage #(
      .CNT_W   (CNT_W),
      .DIV_RST (DIV_INIT[k*CNT_W +: CNT_W])
    ) u_stage (
      .clk        (clk),
      .reset      (reset),
      .strobe_in  (s[k]),
      .clr        (clr),
      .load       (cfg_load),
      .div_in     (cfg_div[k*CNT_W +: CNT_W]),
      .strobe_out (s[k+1]),
      .tick       (tick_o[k]),
      .sq         (sq_o[k])
    );
  end

endmodule
